// File: rtl/video_timing_pkg.sv
// Shared types, register field map and colour-bar table for video_timing_gen.
package video_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned FCNT_W = 16;

  // CTRL register bits
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_TP_BIT   = 1;
  localparam int unsigned CTRL_RECT_BIT = 2;

  // COLOR register fields
  localparam int unsigned COLOR_BG_LSB = 0;
  localparam int unsigned COLOR_GB_LSB = 16;
  localparam int unsigned COLOR_GB_W   = 8;

  // RECT_POS / RECT_SIZE register fields
  localparam int unsigned RECT_X_LSB = 0;
  localparam int unsigned RECT_Y_LSB = 16;
  localparam int unsigned RECT_W_LSB = 0;
  localparam int unsigned RECT_H_LSB = 16;
  localparam int unsigned RECT_R_LSB = 28;
  localparam int unsigned RECT_R_W   = 4;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Frame-stable copy of the register bank
  typedef struct packed {
    logic en;
    logic tp;
    logic rect_en;
    rgb_t bg;
    rgb_t rect_rgb;
    cnt_t rect_x;
    cnt_t rect_y;
    cnt_t rect_w;
    cnt_t rect_h;
  } shadow_t;

  // Registered pixel-side outputs
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    rgb_t rgb;
  } pix_t;

  // Eight vertical colour bars, 128 pixels each
  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;  // white
      3'd1:    bar_color = 12'hFF0;  // yellow
      3'd2:    bar_color = 12'h0FF;  // cyan
      3'd3:    bar_color = 12'h0F0;  // green
      3'd4:    bar_color = 12'hF0F;  // magenta
      3'd5:    bar_color = 12'hF00;  // red
      3'd6:    bar_color = 12'h00F;  // blue
      default: bar_color = 12'h000;  // black
    endcase
  endfunction

endpackage

// File: rtl/video_ce_div.sv
// Pixel clock-enable divider: one pix_ce pulse every CLK_DIV ACLK cycles.
module video_ce_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clear_i,
  output logic pix_ce_c_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Count 0..CLK_DIV-1, parked at zero while cleared
  always_comb begin
    div_d = div_q;
    if (clear_i || (div_q == DIV_LAST)) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_ce_c_o = !clear_i && (div_q == DIV_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// VGA-style timing generator with frame-shadowed registers, colour bars and one overlay rectangle.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [31:0]       ctrl_reg,
  input  logic [31:0]       color_reg,
  input  logic [31:0]       rect_pos_reg,
  input  logic [31:0]       rect_size_reg,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [RGB_W-1:0]  rgb,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam cnt_t H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam cnt_t V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST     = CNT_W'(V_TOTAL - 1);

  localparam pix_t PIX_RESET = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0, rgb: '0};

  state_t            state_q, state_d;
  cnt_t              h_q, h_d;
  cnt_t              v_q, v_d;
  shadow_t           shd_q, shd_d;
  pix_t              pix_q, pix_d;
  logic              frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  shadow_t           live_shd_c;
  pix_t              pix_c;
  logic              pix_ce_c;
  logic              frame_end_c;
  logic              unused_bits_c;

  video_ce_div #(
    .CLK_DIV(CLK_DIV)
  ) u_ce_div (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .clear_i   (state_q == IDLE),
    .pix_ce_c_o(pix_ce_c)
  );

  // Register fields this block does not consume
  assign unused_bits_c = ^{ctrl_reg[31:3], color_reg[31:24], color_reg[15:12],
                           rect_pos_reg[31:27], rect_pos_reg[15:11],
                           rect_size_reg[27], rect_size_reg[15:11]};

  // Unpack the live register bank into shadow form
  always_comb begin
    live_shd_c          = '0;
    live_shd_c.en       = ctrl_reg[CTRL_EN_BIT];
    live_shd_c.tp       = ctrl_reg[CTRL_TP_BIT];
    live_shd_c.rect_en  = ctrl_reg[CTRL_RECT_BIT];
    live_shd_c.bg       = color_reg[COLOR_BG_LSB +: RGB_W];
    live_shd_c.rect_rgb = {rect_size_reg[RECT_R_LSB +: RECT_R_W], color_reg[COLOR_GB_LSB +: COLOR_GB_W]};
    live_shd_c.rect_x   = rect_pos_reg[RECT_X_LSB +: CNT_W];
    live_shd_c.rect_y   = rect_pos_reg[RECT_Y_LSB +: CNT_W];
    live_shd_c.rect_w   = rect_size_reg[RECT_W_LSB +: CNT_W];
    live_shd_c.rect_h   = rect_size_reg[RECT_H_LSB +: CNT_W];
  end

  // Decode the current pixel position into sync, enable and colour
  always_comb begin
    logic [CNT_W:0] x_end;
    logic [CNT_W:0] y_end;
    logic           rect_hit;
    pix_c    = PIX_RESET;
    x_end    = {1'b0, shd_q.rect_x} + {1'b0, shd_q.rect_w};
    y_end    = {1'b0, shd_q.rect_y} + {1'b0, shd_q.rect_h};
    rect_hit = shd_q.rect_en
               && (h_q >= shd_q.rect_x) && ({1'b0, h_q} < x_end)
               && (v_q >= shd_q.rect_y) && ({1'b0, v_q} < y_end);
    pix_c.de    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    pix_c.hsync = ((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    pix_c.vsync = ((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    if (!pix_c.de) begin
      pix_c.rgb = '0;
    end else if (rect_hit) begin
      pix_c.rgb = shd_q.rect_rgb;
    end else if (shd_q.tp) begin
      pix_c.rgb = bar_color(h_q[9:7]);
    end else begin
      pix_c.rgb = shd_q.bg;
    end
  end

  assign frame_end_c = pix_ce_c && (h_q == H_LAST) && (v_q == V_LAST);

  // Next-state: idle/run control, raster counters, shadows and output pipeline
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    v_d           = v_q;
    shd_d         = shd_q;
    pix_d         = pix_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    case (state_q)
      IDLE: begin
        h_d         = '0;
        v_d         = '0;
        pix_d       = PIX_RESET;
        frame_cnt_d = '0;
        shd_d       = live_shd_c;
        if (ctrl_reg[CTRL_EN_BIT]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pix_ce_c) begin
          pix_d         = pix_c;
          frame_start_d = (h_q == '0) && (v_q == '0);
          if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
          end else begin
            h_d = h_q + CNT_W'(1);
          end
        end
        // Only a frame boundary may pick up new settings or stop the raster
        if (frame_end_c) begin
          shd_d       = live_shd_c;
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          if (!live_shd_c.en) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      shd_q         <= '0;
      pix_q         <= PIX_RESET;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      shd_q         <= shd_d;
      pix_q         <= pix_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync       = pix_q.hsync;
  assign vsync       = pix_q.vsync;
  assign de          = pix_q.de;
  assign rgb         = pix_q.rgb;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
